// File: rtl/instr_seq_ctrl_pkg.sv
// Shared definitions for the instruction sequencer.
// Contents: opcode values, IR field positions, FSM state encoding and a control-opcode helper.
package instr_seq_ctrl_pkg;

    // Width of the oper field at the top of every instruction word.
    localparam int unsigned OPER_W = 5;

    // IR field positions: oper/rdst/rsrc1/mode/rsrc2/imm_data.
    localparam int unsigned OPER_MSB  = 31;
    localparam int unsigned OPER_LSB  = 27;
    localparam int unsigned RDST_MSB  = 26;
    localparam int unsigned RDST_LSB  = 22;
    localparam int unsigned RSRC1_MSB = 21;
    localparam int unsigned RSRC1_LSB = 17;
    localparam int unsigned MODE_BIT  = 16;
    localparam int unsigned RSRC2_MSB = 15;
    localparam int unsigned RSRC2_LSB = 11;
    localparam int unsigned IMM_MSB   = 15;
    localparam int unsigned IMM_LSB   = 0;

    // Datapath opcodes. The sequencer only forwards these with an exec strobe.
    localparam logic [OPER_W-1:0] OP_MOVSGPR  = 5'b00000;
    localparam logic [OPER_W-1:0] OP_MOV      = 5'b00001;
    localparam logic [OPER_W-1:0] OP_ADD      = 5'b00010;
    localparam logic [OPER_W-1:0] OP_SUB      = 5'b00011;
    localparam logic [OPER_W-1:0] OP_MUL      = 5'b00100;
    localparam logic [OPER_W-1:0] OP_OR       = 5'b00101;
    localparam logic [OPER_W-1:0] OP_AND      = 5'b00110;
    localparam logic [OPER_W-1:0] OP_XOR      = 5'b00111;
    localparam logic [OPER_W-1:0] OP_XNOR     = 5'b01000;
    localparam logic [OPER_W-1:0] OP_NAND     = 5'b01001;
    localparam logic [OPER_W-1:0] OP_NOR      = 5'b01010;
    localparam logic [OPER_W-1:0] OP_OPER_NOT = 5'b01011;

    // Control-flow opcodes handled entirely inside the sequencer.
    localparam logic [OPER_W-1:0] OP_JMP  = 5'b01100;
    localparam logic [OPER_W-1:0] OP_JZ   = 5'b01101;
    localparam logic [OPER_W-1:0] OP_JNZ  = 5'b01110;
    localparam logic [OPER_W-1:0] OP_HALT = 5'b01111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_DELAY = 3'd4,
        ST_NEXT  = 3'd5,
        ST_HALT  = 3'd6
    } seq_state_e;

    // True for opcodes the sequencer consumes itself (no exec strobe).
    function automatic logic is_ctrl_op(input logic [OPER_W-1:0] op);
        return (op == OP_JMP) || (op == OP_JZ) || (op == OP_JNZ) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/instr_seq_ctrl_delay_cnt.sv
// Settle-time counter for the DELAY state: cleared on load, counts while enabled.
// done is high once the count reaches EXEC_CYCLES-2.
module seq_delay_cnt #(
    parameter int unsigned EXEC_CYCLES = 4
) (
    input  logic clk,
    input  logic sysreset,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int unsigned CW   = (EXEC_CYCLES > 2) ? $clog2(EXEC_CYCLES - 1) : 1;
    localparam int unsigned LAST = (EXEC_CYCLES >= 2) ? (EXEC_CYCLES - 2) : 0;
    localparam logic [CW-1:0] LAST_C = CW'(LAST);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear on load, advance while enabled, saturate at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST_C)) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (sysreset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == LAST_C);

endmodule

// File: rtl/instr_seq_ctrl.sv
// Fetch/execute sequencer: owns the PC, fetches from progmem, holds IR and issues one
// exec strobe per datapath instruction. jmp/jz/jnz/halt are resolved here in NEXT.
// All outputs are registered from the next-state decode, so they line up with the state.
module instr_seq_ctrl
    import instr_seq_ctrl_pkg::*;
#(
    parameter int unsigned IW          = 32,
    parameter int unsigned PM_DEPTH    = 8,
    parameter int unsigned AW          = 3,
    parameter int unsigned EXEC_CYCLES = 4
) (
    input  logic          clk,
    input  logic          sysreset,
    input  logic          start,
    output logic          pm_rd,
    output logic [AW-1:0] pm_addr,
    input  logic [IW-1:0] pm_rdata,
    output logic [IW-1:0] ir,
    output logic          exec_en,
    input  logic          zero_flag,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(PM_DEPTH);

    seq_state_e    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [IW-1:0] ir_q, ir_d;
    logic          pm_rd_q, pm_rd_d;
    logic [AW-1:0] pm_addr_q, pm_addr_d;
    logic          exec_en_q, exec_en_d;
    logic          busy_q, busy_d;
    logic          halted_q, halted_d;

    logic              cnt_load_s;
    logic              cnt_en_s;
    logic              cnt_done_s;
    logic [OPER_W-1:0] oper_s;
    logic [AW-1:0]     pc_inc_s;
    logic [AW-1:0]     pc_tgt_s;

    // Reduce an (AW+1)-bit value into 0..PM_DEPTH-1; inputs never reach 2*PM_DEPTH.
    function automatic logic [AW-1:0] wrap_pc(input logic [AW:0] v);
        logic [AW:0] t;
        if (v >= DEPTH_W) begin
            t = v - DEPTH_W;
        end else begin
            t = v;
        end
        return t[AW-1:0];
    endfunction

    assign oper_s   = ir_q[IW-1 -: OPER_W];
    assign pc_inc_s = wrap_pc({1'b0, pc_q} + {{AW{1'b0}}, 1'b1});
    assign pc_tgt_s = wrap_pc({1'b0, ir_q[AW-1:0]});

    seq_delay_cnt #(
        .EXEC_CYCLES (EXEC_CYCLES)
    ) u_delay_cnt (
        .clk      (clk),
        .sysreset (sysreset),
        .load     (cnt_load_s),
        .en       (cnt_en_s),
        .done     (cnt_done_s)
    );

    // State, PC, IR and registered-output flops; reset dominates start.
    always_ff @(posedge clk) begin
        if (sysreset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            pm_rd_q   <= 1'b0;
            pm_addr_q <= '0;
            exec_en_q <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            pm_rd_q   <= pm_rd_d;
            pm_addr_q <= pm_addr_d;
            exec_en_q <= exec_en_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
        end
    end

    // Next-state, PC and IR selection, including branch resolution in NEXT.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        cnt_load_s = 1'b0;
        cnt_en_s   = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                ir_d    = pm_rdata;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                cnt_load_s = 1'b1;
                if (EXEC_CYCLES > 1) begin
                    state_d = ST_DELAY;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_DELAY: begin
                cnt_en_s = 1'b1;
                if (cnt_done_s) begin
                    state_d = ST_NEXT;
                end else begin
                    state_d = ST_DELAY;
                end
            end
            ST_NEXT: begin
                state_d = ST_FETCH;
                case (oper_s)
                    OP_JMP: pc_d = pc_tgt_s;
                    OP_JZ: begin
                        if (zero_flag) begin
                            pc_d = pc_tgt_s;
                        end else begin
                            pc_d = pc_inc_s;
                        end
                    end
                    OP_JNZ: begin
                        if (!zero_flag) begin
                            pc_d = pc_tgt_s;
                        end else begin
                            pc_d = pc_inc_s;
                        end
                    end
                    OP_HALT: begin
                        state_d = ST_HALT;
                        pc_d    = pc_q;
                    end
                    default: pc_d = pc_inc_s;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs track the state.
    always_comb begin
        pm_rd_d   = (state_d == ST_FETCH);
        exec_en_d = 1'b0;
        busy_d    = 1'b0;
        halted_d  = (state_d == ST_HALT);
        if (pm_rd_d) begin
            pm_addr_d = pc_d;
        end else begin
            pm_addr_d = '0;
        end
        if (state_d == ST_EXEC) begin
            exec_en_d = !is_ctrl_op(ir_d[IW-1 -: OPER_W]);
        end else begin
            exec_en_d = 1'b0;
        end
        case (state_d)
            ST_FETCH, ST_LOAD, ST_EXEC, ST_DELAY, ST_NEXT: busy_d = 1'b1;
            default:                                       busy_d = 1'b0;
        endcase
    end

    assign pm_rd   = pm_rd_q;
    assign pm_addr = pm_addr_q;
    assign ir      = ir_q;
    assign exec_en = exec_en_q;
    assign pc      = pc_q;
    assign busy    = busy_q;
    assign halted  = halted_q;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Self-checking bench for instr_seq_ctrl: directed programs plus random programs,
// compared against an instruction-level reference model of the sequencer timeline.
module tb_instr_seq_ctrl;

    localparam int D  = 8;
    localparam int EC = 4;

    logic        clk = 1'b0;
    logic        sysreset = 1'b1;
    logic        start = 1'b0;
    logic        pm_rd;
    logic [2:0]  pm_addr;
    logic [31:0] pm_rdata = 32'd0;
    logic [31:0] ir;
    logic        exec_en;
    logic        zero_flag = 1'b0;
    logic [2:0]  pc;
    logic        busy;
    logic        halted;

    logic [31:0] prog [D];
    int          mpc;
    int          tests = 0;
    int          fails = 0;

    instr_seq_ctrl dut (
        .clk       (clk),
        .sysreset  (sysreset),
        .start     (start),
        .pm_rd     (pm_rd),
        .pm_addr   (pm_addr),
        .pm_rdata  (pm_rdata),
        .ir        (ir),
        .exec_en   (exec_en),
        .zero_flag (zero_flag),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // Program memory: data is valid the cycle after the read request.
    always @(posedge clk) begin
        if (pm_rd) pm_rdata <= prog[pm_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_dp_word();
        logic [4:0] op;
        op = 5'($urandom_range(0, 27));
        if (op >= 5'd12) op = op + 5'd4;   // skip the four control opcodes
        return {op, 27'($urandom)};
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_busy"},    32'(busy),    32'd0);
        check({tag, "_halted"},  32'(halted),  32'd0);
        check({tag, "_pc"},      32'(pc),      32'd0);
        check({tag, "_ir"},      ir,           32'd0);
        check({tag, "_exec_en"}, 32'(exec_en), 32'd0);
        check({tag, "_pm_rd"},   32'(pm_rd),   32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        sysreset = 1'b1;
        start    = 1'b1;              // reset must win over a simultaneous start
        @(negedge clk);
        start    = 1'b0;
        @(negedge clk);
        sysreset = 1'b0;
        mpc      = 0;
        check_idle("reset");
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mpc   = 0;
    endtask

    // Walk the model through up to max_instr instructions starting at a FETCH cycle.
    // zf_mode: 0 force zero_flag low, 1 force high, 2 random per instruction.
    task automatic run_prog(input int max_instr, input int zf_mode, input bit poke);
        logic [31:0] w;
        int          op;
        int          tgt;
        bit          zf;
        bit          ctrl;
        bit          stop;
        stop = 1'b0;
        for (int k = 0; k < max_instr && !stop; k++) begin
            check("fetch_rd",   32'(pm_rd),   32'd1);
            check("fetch_addr", 32'(pm_addr), 32'(mpc));
            check("fetch_pc",   32'(pc),      32'(mpc));
            check("fetch_busy", 32'(busy),    32'd1);
            zf = (zf_mode == 2) ? 1'($urandom_range(0, 1)) : (zf_mode == 1);
            zero_flag = zf;
            w    = prog[mpc];
            op   = int'(w[31:27]);
            ctrl = (op >= 12) && (op <= 15);
            tgt  = int'(w[2:0]) % D;
            @(negedge clk);
            check("load_exec_en", 32'(exec_en), 32'd0);
            @(negedge clk);
            check("exec_ir", ir, w);
            check("exec_en", 32'(exec_en), 32'(!ctrl));
            for (int d = 0; d < EC - 1; d++) begin
                @(negedge clk);
                start = poke && (k == 0) && (d == 0);
                check("delay_exec_en", 32'(exec_en), 32'd0);
                check("delay_busy",    32'(busy),    32'd1);
            end
            @(negedge clk);
            start = 1'b0;
            check("next_exec_en", 32'(exec_en), 32'd0);
            check("next_pc",      32'(pc),      32'(mpc));
            @(negedge clk);
            if (op == 15) begin
                check("halt_halted",  32'(halted),  32'd1);
                check("halt_busy",    32'(busy),    32'd0);
                check("halt_pc",      32'(pc),      32'(mpc));
                check("halt_ir",      ir,           w);
                check("halt_exec_en", 32'(exec_en), 32'd0);
                stop = 1'b1;
            end else if (op == 12) begin
                mpc = tgt;
            end else if (op == 13) begin
                mpc = zf ? tgt : (mpc + 1) % D;
            end else if (op == 14) begin
                mpc = !zf ? tgt : (mpc + 1) % D;
            end else begin
                mpc = (mpc + 1) % D;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < D; i++) prog[i] = rand_dp_word();

        // Power-on reset
        do_reset();

        // Straight-line program ending in halt
        prog[0] = {5'b00001, 5'd1, 5'd0, 1'b1, 16'd5};
        prog[1] = {5'b00010, 5'd2, 5'd1, 1'b1, 16'd3};
        prog[2] = {5'b01111, 27'd0};
        do_start();
        run_prog(6, 0, 1'b1);          // also pokes start while busy
        check("line_halted", 32'(halted), 32'd1);
        check("line_pc",     32'(pc),     32'd2);

        // start in HALT restarts at address 0
        do_start();
        check("restart_addr", 32'(pm_addr), 32'd0);
        run_prog(6, 0, 1'b0);

        // Reset in the middle of DELAY
        do_start();
        repeat (3) @(negedge clk);
        check("mid_delay_busy", 32'(busy), 32'd1);
        do_reset();

        // PC wrap across eight datapath words
        for (int i = 0; i < D; i++) prog[i] = rand_dp_word();
        do_start();
        run_prog(8, 2, 1'b0);
        check("wrap_addr", 32'(pm_addr), 32'd0);
        run_prog(1, 2, 1'b0);
        do_reset();

        // jz taken and not taken
        prog[2] = {5'b01101, 24'd0, 3'd5};
        do_start();
        run_prog(3, 1, 1'b0);
        check("jz_taken", 32'(pm_addr), 32'd5);
        do_reset();
        do_start();
        run_prog(3, 0, 1'b0);
        check("jz_not_taken", 32'(pm_addr), 32'd3);
        do_reset();

        // jmp 0 tight loop
        prog[0] = {5'b01100, 27'd0};
        do_start();
        run_prog(5, 2, 1'b0);
        check("jmp_loop_addr", 32'(pm_addr), 32'd0);
        check("jmp_loop_busy", 32'(busy),    32'd1);
        do_reset();

        // Random programs mixing datapath, unused and control opcodes
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < D; i++) prog[i] = $urandom;
            do_start();
            run_prog(16, 2, r[0]);
            do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
